logic_unit_pipe: RTL
====================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result bit width (>=1).
REQ-002 Parameter PIPE_STAGES, default 2, register stages from input to output (>=1).
REQ-003 Parameter CNT_W, default 16, width of accepted-operation counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  block can accept operand set this cycle.
REQ-008 in_a  input  WIDTH  operand A.
REQ-009 in_b  input  WIDTH  operand B.
REQ-010 in_op  input  3  operation select.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_y  output  WIDTH  result.
REQ-014 out_zero  output  1  out_y is all zeros.
REQ-015 out_ones  output  1  out_y is all ones.
REQ-016 op_count  output  CNT_W  number of accepted operations, saturating.

Function
REQ-017 Op encoding, bitwise on A and B: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT_A, 7 PASS_A; all 8 codes are legal.
REQ-018 Result and both flags are computed combinationally before stage 1 and carried through the pipeline with the result.
REQ-019 Transfer occurs on a rising edge where valid and ready are both high, at input and at output.
REQ-020 Each stage holds one entry and a valid bit; it loads when empty or when its downstream transfers in the same cycle.
REQ-021 in_ready = stage 1 empty OR stage 1 advancing this cycle; ready may be combinational from out_ready.
REQ-022 Latency: out_valid rises exactly PIPE_STAGES cycles after the accepting edge when out_ready is held high.
REQ-023 Throughput: one operation per cycle sustained with out_ready high; no bubbles are inserted.
REQ-024 Backpressure: while out_valid=1 and out_ready=0, out_y/out_zero/out_ones are held stable and no entry is lost or duplicated.
REQ-025 With all stages full and out_ready=0, in_ready=0; a full pipe with out_ready=1 accepts and emits in the same cycle.
REQ-026 Ordering: results leave in acceptance order.
REQ-027 op_count increments by 1 on each input transfer and stays at 2^CNT_W-1 once reached (no wrap).
REQ-028 Inputs are ignored when in_valid=0; in_a/in_b/in_op values with in_valid=0 have no effect.

Reset
REQ-029 rst_n=0 clears every stage valid bit, data, and flags to 0 immediately, without waiting for clk.
REQ-030 During reset: out_valid=0, out_y=0, out_zero=0, out_ones=0, op_count=0, in_ready=0.
REQ-031 Reset asserted mid-operation discards all in-flight entries; none appear after release.
REQ-032 in_ready rises on the first rising edge after rst_n deasserts.

Structure
REQ-033 Opcode localparams (OP_AND..OP_PASS_A) and the op width constant live in shared package logic_unit_pkg.
REQ-034 One sub-module, logic_unit_stage: a single valid/ready register slice, parametrised on payload width (WIDTH+2).
REQ-035 logic_unit_pipe instantiates PIPE_STAGES logic_unit_stage instances in a generate chain.

Verification
REQ-036 WIDTH=8, a=8'hF0, b=8'hCC, ops 0..7 back-to-back, out_ready=1 -> out_y = C0, FC, 3C, 3F, 03, C3, 0F, F0, one per cycle, first at cycle 2.
REQ-037 a=8'h00, b=8'h00, op AND -> out_zero=1, out_ones=0; a=8'hFF, op PASS_A -> out_ones=1, out_zero=0.
REQ-038 Send 4 ops with out_ready=0 -> after 2 accepts in_ready=0, out_y stable; raise out_ready -> all 4 results in order, no loss or duplication.
REQ-039 Reset pulsed with 2 ops in flight -> out_valid=0 immediately, op_count=0, no stale result after release.
REQ-040 CNT_W=4, 20 accepted ops -> op_count reads 15 and holds.
REQ-041 PIPE_STAGES=1, continuous traffic with random out_ready -> latency 1, results match bitwise model in order.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared opcode encoding for the pipelined bitwise logic unit.
package logic_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND    = 3'd0;
    localparam logic [OP_W-1:0] OP_OR     = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR    = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND   = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR    = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR   = 3'd5;
    localparam logic [OP_W-1:0] OP_NOT_A  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS_A = 3'd7;

endpackage

// File: rtl/logic_unit_stage.sv
// One valid/ready register slice: holds a single payload and its valid bit.
module logic_unit_stage #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Accept when empty, or when the held entry leaves on this same edge.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit: result and zero/ones flags computed up front, then
// carried through a chain of PIPE_STAGES valid/ready slices.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic [CNT_W-1:0] op_count
);

    localparam int PW = WIDTH + 2;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, ready may depend on out_ready.

    logic             ready_en;
    logic [WIDTH-1:0] y_c;
    logic             v [PIPE_STAGES+1];
    logic             r [PIPE_STAGES+1];
    logic [PW-1:0]    d [PIPE_STAGES+1];

    // Holds in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        y_c = '0;
        case (in_op)
            OP_AND:    y_c = in_a & in_b;
            OP_OR:     y_c = in_a | in_b;
            OP_XOR:    y_c = in_a ^ in_b;
            OP_NAND:   y_c = ~(in_a & in_b);
            OP_NOR:    y_c = ~(in_a | in_b);
            OP_XNOR:   y_c = ~(in_a ^ in_b);
            OP_NOT_A:  y_c = ~in_a;
            OP_PASS_A: y_c = in_a;
            default:   y_c = in_a;
        endcase
    end

    assign v[0]     = in_valid && ready_en;
    assign d[0]     = {(y_c == '0), (y_c == '1), y_c};
    assign in_ready = r[0] && ready_en;

    for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
        logic_unit_stage #(
            .W(PW)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (v[g]),
            .in_ready (r[g]),
            .in_data  (d[g]),
            .out_valid(v[g+1]),
            .out_ready(r[g+1]),
            .out_data (d[g+1])
        );
    end

    assign r[PIPE_STAGES]                = out_ready;
    assign out_valid                     = v[PIPE_STAGES];
    assign {out_zero, out_ones, out_y}   = d[PIPE_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (in_valid && in_ready && (op_count != '1)) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule
